// File: rtl/dly_pkg.sv
// rtl/dly_pkg.sv - shared helpers for the programmable delay line (DLY_ZERO_BYPASS_EN selects minimum delay)
package dly_pkg;

`ifdef DLY_ZERO_BYPASS_EN
  localparam int unsigned DLY_MIN = 0;
`else
  localparam int unsigned DLY_MIN = 1;
`endif

  function automatic int dly_clog2(input int unsigned v);
    int r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  // Requested delay forced into DLY_MIN..max_d; a mismatch with the request marks a config error.
  function automatic int unsigned dly_clamp(input int unsigned num, input int unsigned max_d);
    if (num > max_d) return max_d;
    if (num == 0) return DLY_MIN;
    return num;
  endfunction

endpackage

// File: rtl/dly_ring_ram.sv
// rtl/dly_ring_ram.sv - circular sample buffer, one write port, one registered read port
// Storage is never reset; only the read register is.
module dly_ring_ram #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q, rd_data_d;

  // Same-address read returns the word being written, which is what makes a delay of 1 work.
  always_comb begin
    rd_data_d = (rd_addr == wr_addr) ? wr_data : mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/delay_line_ram.sv
// rtl/delay_line_ram.sv - WIDTH-bit + valid delay line, run-time delay 1..MAX_DELAY
// Optional DLY_ZERO_BYPASS_EN allows delay 0 as a combinational pass-through.
module delay_line_ram
  import dly_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int MAX_DELAY     = 32,
  parameter int DEFAULT_DELAY = 1,
  parameter int DW            = dly_clog2(MAX_DELAY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_vld,
  input  logic [DW-1:0]    delay_num,
  input  logic             delay_load,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  output logic [DW-1:0]    delay_cur,
  output logic             busy,
  output logic             cfg_err
);

  localparam int AW = dly_clog2(MAX_DELAY);
  localparam int SW = DW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_addr;
  logic [DW-1:0] fill_cnt_q, fill_cnt_d;
  logic [DW-1:0] delay_cur_q, delay_cur_d;
  logic [DW-1:0] num_clamped, d_eff;
  logic          cfg_err_q, cfg_err_d;
  logic [SW-1:0] rd_sum;
  logic [WIDTH:0] rd_data;

  // The read register captures the sample for the next cycle, so it is addressed with
  // the delay that will be in force then, reaching back D-1 slots from the write slot.
  always_comb begin
    num_clamped = DW'(dly_clamp(32'(delay_num), MAX_DELAY));
    delay_cur_d = delay_load ? num_clamped : delay_cur_q;
    cfg_err_d   = delay_load && (num_clamped != delay_num);
    wr_ptr_d    = (wr_ptr_q == AW'(MAX_DELAY - 1)) ? '0 : wr_ptr_q + AW'(1);
    fill_cnt_d  = (fill_cnt_q == DW'(MAX_DELAY)) ? fill_cnt_q : fill_cnt_q + DW'(1);
    d_eff       = (delay_cur_d == '0) ? DW'(1) : delay_cur_d;
    rd_sum      = SW'(wr_ptr_q) + SW'(MAX_DELAY + 1) - SW'(d_eff);
    if (rd_sum >= SW'(MAX_DELAY)) rd_sum = rd_sum - SW'(MAX_DELAY);
    rd_addr     = AW'(rd_sum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      fill_cnt_q  <= '0;
      delay_cur_q <= DW'(DEFAULT_DELAY);
      cfg_err_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      fill_cnt_q  <= fill_cnt_d;
      delay_cur_q <= delay_cur_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  dly_ring_ram #(
    .WIDTH (WIDTH + 1),
    .DEPTH (MAX_DELAY),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_addr (wr_ptr_q),
    .wr_data ({din_vld, din}),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign delay_cur = delay_cur_q;
  assign busy      = fill_cnt_q < delay_cur_q;
  assign cfg_err   = cfg_err_q;

`ifdef DLY_ZERO_BYPASS_EN
  assign dout     = (delay_cur_q == '0) ? din : rd_data[WIDTH-1:0];
  assign dout_vld = (delay_cur_q == '0) ? din_vld : (rd_data[WIDTH] & ~busy);
`else
  assign dout     = rd_data[WIDTH-1:0];
  assign dout_vld = rd_data[WIDTH] & ~busy;
`endif

endmodule

// File: tb/tb_delay_line_ram.sv
// tb/tb_delay_line_ram.sv - scoreboard bench for delay_line_ram (honours DLY_ZERO_BYPASS_EN)
module tb_delay_line_ram;

  localparam int W  = 8;
  localparam int M  = 32;
  localparam int DD = 1;
  localparam int DW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  din = '0;
  logic          din_vld = 1'b0;
  logic [DW-1:0] delay_num = '0;
  logic          delay_load = 1'b0;
  logic [W-1:0]  dout;
  logic          dout_vld;
  logic [DW-1:0] delay_cur;
  logic          busy;
  logic          cfg_err;

  delay_line_ram #(.WIDTH(W), .MAX_DELAY(M), .DEFAULT_DELAY(DD)) dut (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld),
    .delay_num(delay_num), .delay_load(delay_load),
    .dout(dout), .dout_vld(dout_vld), .delay_cur(delay_cur),
    .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          vld;
    logic [DW-1:0] dc;
    logic          busy;
    logic          err;
  } ctl_t;

  ctl_t         ctl_q[$];
  logic [W-1:0] data_q[$];
  logic [W-1:0] hist_d[$];
  logic         hist_v[$];

  int checks = 0;
  int failures = 0;
  bit known = 0;
  int cyc = 0;
  int m_delay = DD;
  bit m_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, record what the outputs must show this cycle,
  // then advance the model across the closing edge.
  task automatic step(input bit r, input logic [W-1:0] d, input bit v, input bit ld, input int num);
    ctl_t e;
    int fill;
    bit ev;
    @(posedge clk); #1;
    rst = r; din = d; din_vld = v; delay_load = ld; delay_num = DW'(num);
    if (known) begin
      fill = (cyc < M) ? cyc : M;
      if (m_delay == 0) ev = v;
      else ev = (cyc >= m_delay) ? hist_v[cyc - m_delay] : 1'b0;
      e.vld = ev; e.dc = DW'(m_delay); e.busy = (fill < m_delay); e.err = m_err;
      ctl_q.push_back(e);
      if (ev) data_q.push_back((m_delay == 0) ? d : hist_d[cyc - m_delay]);
    end
    if (r) begin
      known = 1; cyc = 0; m_delay = DD; m_err = 0;
      hist_d.delete(); hist_v.delete();
    end else if (known) begin
      hist_d.push_back(d); hist_v.push_back(v); cyc++;
      m_err = 0;
      if (ld) begin
        if (num > M) begin m_delay = M; m_err = 1; end
`ifdef DLY_ZERO_BYPASS_EN
        else if (num == 0) m_delay = 0;
`else
        else if (num == 0) begin m_delay = 1; m_err = 1; end
`endif
        else m_delay = num;
      end
    end
  endtask

  always @(negedge clk) begin
    ctl_t e;
    logic [W-1:0] ed;
    if (ctl_q.size() > 0) begin
      e = ctl_q.pop_front();
      chk("dout_vld", int'(dout_vld), int'(e.vld));
      chk("delay_cur", int'(delay_cur), int'(e.dc));
      chk("busy", int'(busy), int'(e.busy));
      chk("cfg_err", int'(cfg_err), int'(e.err));
      if (dout_vld === 1'b1) begin
        if (data_q.size() == 0) chk("data_underflow", 1, 0);
        else begin
          ed = data_q.pop_front();
          chk("dout", int'(dout), int'(ed));
        end
      end else if (e.vld && data_q.size() > 0) begin
        void'(data_q.pop_front());
      end
    end
  end

  initial begin
    // reset, D=1 ramp
    step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, W'(i), 1, 0, 0);
    // load 5 on a running stream
    step(0, 8'd10, 1, 1, 5);
    for (int i = 11; i < 30; i++) step(0, W'(i), 1, 0, 0);
    // load MAX_DELAY shortly after reset
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, W'(i + 100), 1, 0, 0);
    step(0, 8'd103, 1, 1, M);
    for (int i = 4; i < 45; i++) step(0, W'(i + 100), 1, 0, 0);
    // out-of-range request clamps to MAX_DELAY
    step(0, 8'h55, 1, 1, 40);
    for (int i = 0; i < 40; i++) step(0, W'(i * 3), i[0], 0, 0);
    // zero request
    step(0, 8'hAA, 1, 1, 0);
    for (int i = 0; i < 6; i++) step(0, W'(i + 200), 1, 0, 0);
    // reset mid-stream at D=8
    step(0, 8'h11, 1, 1, 8);
    for (int i = 0; i < 20; i++) step(0, W'(i + 50), 1, 0, 0);
    step(1, 8'hEE, 1, 0, 0);
    for (int i = 0; i < 12; i++) step(0, W'(i + 70), 1, 0, 0);
    // randomized traffic with occasional loads and resets
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 199) == 0), W'($urandom), $urandom_range(0, 3) != 0,
           ($urandom_range(0, 24) == 0), int'($urandom_range(0, 40)));
    end
    step(0, 0, 0, 0, 0);
    @(negedge clk); #1;
    chk("scoreboard_drained", data_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
